// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Loads Tx_dv/Tx_Byte, waits for Tx_done under a watchdog, then idles GAP_CLKS clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 4,
  parameter int TIMEOUT_CLKS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 Tx_dv,
  output logic [7:0]           Tx_Byte,
  input  logic                 Tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int LW   = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CLKS) + 1;
  localparam int GC_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  state_t             state, state_n;
  logic [LW-1:0]      last, last_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic [GC_W-1:0]    gc, gc_n;
  logic [7:0]         byte_n;
  logic [NUM_REQ-1:0] grant_n;
  logic               dv_n, busy_n, terr_n;

  logic [LW-1:0]      win, idx;
  logic               found;

  // Search starts just past the last winner so every holder is served in turn.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((int'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    wd_n    = wd;
    gc_n    = gc;
    byte_n  = Tx_Byte;
    grant_n = '0;
    dv_n    = 1'b0;
    terr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          last_n  = win;
          byte_n  = req_byte[{win, 3'b000} +: 8];
          grant_n = NUM_REQ'(1) << win;
          dv_n    = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wd_n = (wd == '1) ? wd : wd + 1'b1;
        gc_n = '0;
        if (Tx_done) begin
          state_n = (GAP_CLKS == 0) ? IDLE : GAP;
        end else if (wd == WD_W'(TIMEOUT_CLKS - 2)) begin
          // Pulse lands on the cycle the watchdog reaches TIMEOUT_CLKS-1.
          terr_n  = 1'b1;
          state_n = (GAP_CLKS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (int'(gc) >= GAP_CLKS - 1) begin
          state_n = IDLE;
        end else begin
          gc_n = (gc == '1) ? gc : gc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= LW'(NUM_REQ - 1);
      wd          <= '0;
      gc          <= '0;
      Tx_Byte     <= 8'h00;
      grant       <= '0;
      Tx_dv       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      wd          <= wd_n;
      gc          <= gc_n;
      Tx_Byte     <= byte_n;
      grant       <= grant_n;
      Tx_dv       <= dv_n;
      busy        <= busy_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter against a
// round-robin/timing reference model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [8*N-1:0] req_byte;
  logic [N-1:0] grant;
  logic         Tx_dv;
  logic [7:0]   Tx_Byte;
  logic         Tx_done;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;
  int m_last = N - 1;

  uart_tx_arbiter #(
    .NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_byte(req_byte),
    .grant(grant), .Tx_dv(Tx_dv), .Tx_Byte(Tx_Byte),
    .Tx_done(Tx_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic wait_dv(output int lat);
    lat = 0;
    while (Tx_dv !== 1'b1 && lat < 300) begin
      tick;
      lat++;
    end
    if (lat >= 300) begin
      checks++;
      errors++;
      $error("FAIL dv_wait: observed no Tx_dv expected Tx_dv within 300");
    end
  endtask

  // One full frame: grant check against the model, then Tx_done after dly.
  task automatic frame(input string tag, input int dly, input bit clr,
                       input int exp_lat);
    int e, lat;
    logic [N-1:0] m;
    m = req;
    wait_dv(lat);
    e = pick(m, m_last);
    if (e < 0) e = 0;
    if (exp_lat >= 0) chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_grant"}, grant, 32'(1 << e));
    chk({tag, "_byte"}, Tx_Byte, req_byte[8*e +: 8]);
    chk({tag, "_busy"}, busy, 1);
    m_last = e;
    if (clr) req[e] = 1'b0;
    repeat (dly) tick;
    Tx_done = 1'b1;
    tick;
    Tx_done = 1'b0;
  endtask

  initial begin
    int e, lat;
    rst = 1'b1; req = '0; req_byte = '0; Tx_done = 1'b0;
    repeat (2) tick;
    chk("rst_dv", Tx_dv, 0);
    chk("rst_byte", Tx_Byte, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    tick;

    // single request
    req_byte = $urandom;
    req_byte[23:16] = 8'hA5;
    req = 4'b0100;
    frame("single", 20, 1, 1);
    repeat (3) tick;
    chk("single_gap_busy", busy, 1);
    tick;
    chk("single_idle", busy, 0);
    Tx_done = 1'b1;
    tick;
    Tx_done = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_dv", Tx_dv, 0);
    repeat (3) tick;

    // round robin with stray done inside the gap
    req_byte = 32'h13121110;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      lat = (i == 0) ? 1 : 5;
      if (i == 2) begin
        tick;
        Tx_done = 1'b1;
        tick;
        Tx_done = 1'b0;
        lat = 3;
      end
      frame("rr", 40, 0, lat);
      if (i == 4) req = '0;
    end
    repeat (8) tick;

    // randomized requests
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(1, 0) == 1) begin
          req_byte[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end
      if (req == '0) req[$urandom_range(N - 1, 0)] = 1'b1;
      frame("rand", $urandom_range(50, 11), 1, (f == 0) ? 1 : 5);
    end
    req = '0;
    repeat (8) tick;

    // watchdog timeout, then the other pending requester
    req_byte = $urandom;
    req = 4'b0011;
    wait_dv(lat);
    e = pick(req, m_last);
    chk("to_grant", grant, 32'(1 << e));
    m_last = e;
    req[e] = 1'b0;
    repeat (62) tick;
    chk("to_early", timeout_err, 0);
    tick;
    chk("to_early2", timeout_err, 0);
    tick;
    chk("to_pulse", timeout_err, 1);
    chk("to_busy", busy, 1);
    tick;
    chk("to_clear", timeout_err, 0);
    frame("to_next", 20, 1, 4);
    repeat (8) tick;

    // Tx_done on the last watchdog cycle beats the timeout
    req = 4'b0100;
    frame("to_race", 63, 1, 1);
    chk("to_race_terr", timeout_err, 0);
    chk("to_race_busy", busy, 1);
    repeat (8) tick;
    chk("to_race_idle", busy, 0);

    // reset during WAIT
    req = 4'b1000;
    wait_dv(lat);
    m_last = 3;
    req = '0;
    repeat (10) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_dv", Tx_dv, 0);
    chk("mid_rst_byte", Tx_Byte, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_terr", timeout_err, 0);
    m_last = N - 1;
    req = 4'b1010;
    frame("post_rst", 15, 1, 1);
    chk("post_rst_first", m_last, 1);
    repeat (70) begin
      tick;
      if (Tx_dv === 1'b1) break;
    end
    chk("post_rst_second", grant, 32'(1 << 3));
    repeat (10) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
